uart_rx: RTL and testbench

//  Serial UART receiver; the downstream peer of uart_tx on the same line format (8N1 default, LSB first).

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_if.sv | 13 +
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receiver.
// The optional parity stage is controlled by the UART_RX_PARITY_EN macro.
package uart_rx_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // The word is zero-extended into 16 bits, so the unused upper bits do not change the result.
    function automatic logic expected_parity(input logic [15:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bus between uart_rx and the APB register block.
interface uart_rx_if #(
    parameter int data_bits = 8
);
    logic [data_bits-1:0] data_out;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 parity_err;

    modport master (output data_out, rx_valid, rx_busy, frame_err, parity_err);
    modport slave  (input  data_out, rx_valid, rx_busy, frame_err, parity_err);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser with a falling-edge detector.
// All flops reset to 1, which matches an idle-high line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);
    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Resynchronisation chain, plus one extra stage for edge detection
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync_out = sync_r;
    assign fall     = prev_r & ~sync_r;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling on the oversample tick, LSB first.
// When UART_RX_PARITY_EN is defined, the frame carries a parity bit, checked with the sense set by parity_odd.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int oversample = OVERSAMPLE_DEF,
    parameter int data_bits  = DATA_BITS_DEF,
    parameter bit parity_odd = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_tick,
    input  logic       rx_en,
    input  logic       rx,
    uart_rx_if.master  bus
);
    localparam int TW = $clog2(oversample);
    localparam int BW = $clog2(data_bits);
    localparam logic [TW-1:0] TICK_MID = TW'(oversample / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(oversample - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(data_bits - 1);

    state_t                state_r, state_n;
    logic [TW-1:0]         tick_r, tick_n;
    logic [BW-1:0]         bit_r, bit_n;
    logic [data_bits-1:0]  shift_r, shift_n;
    logic [data_bits-1:0]  data_r, data_n;
    logic                  mis_r, mis_n;
    logic                  valid_r, valid_n;
    logic                  ferr_r, ferr_n;
    logic                  perr_r, perr_n;
    logic                  busy_r;
    logic                  rx_sync_s;
    logic                  rx_fall_s;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (rx),
        .sync_out (rx_sync_s),
        .fall     (rx_fall_s)
    );

`ifndef UART_RX_PARITY_EN
    logic unused_parity_odd_s;
    assign unused_parity_odd_s = parity_odd;
`endif

    // State, counters and output pulse registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r <= ST_IDLE;
            tick_r  <= '0;
            bit_r   <= '0;
            shift_r <= '0;
            data_r  <= '0;
            mis_r   <= 1'b0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            perr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            tick_r  <= tick_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            data_r  <= data_n;
            mis_r   <= mis_n;
            valid_r <= valid_n;
            ferr_r  <= ferr_n;
            perr_r  <= perr_n;
            busy_r  <= (state_n != ST_IDLE);
        end
    end

    // Next-state logic; a bit is sampled only on clocks where s_tick is high
    always_comb begin
        state_n = state_r;
        tick_n  = tick_r;
        bit_n   = bit_r;
        shift_n = shift_r;
        data_n  = data_r;
        mis_n   = mis_r;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        perr_n  = 1'b0;
        if (!rx_en) begin
            state_n = ST_IDLE;
            tick_n  = '0;
            bit_n   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Only a fresh falling edge arms the receiver, so a line held low (break) is ignored
                    if (rx_fall_s) begin
                        state_n = ST_START;
                        tick_n  = '0;
                        mis_n   = 1'b0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (tick_r == TICK_MID) begin
                            tick_n  = '0;
                            bit_n   = '0;
                            state_n = rx_sync_s ? ST_IDLE : ST_DATA;
                        end else begin
                            tick_n = tick_r + TW'(1);
                        end
                    end else begin
                        tick_n = tick_r;
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (tick_r == TICK_END) begin
                            tick_n  = '0;
                            shift_n = {rx_sync_s, shift_r[data_bits-1:1]};
                            if (bit_r == BIT_LAST) begin
                                bit_n = '0;
`ifdef UART_RX_PARITY_EN
                                state_n = ST_PARITY;
`else
                                state_n = ST_STOP;
`endif
                            end else begin
                                bit_n = bit_r + BW'(1);
                            end
                        end else begin
                            tick_n = tick_r + TW'(1);
                        end
                    end else begin
                        tick_n = tick_r;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (s_tick) begin
                        if (tick_r == TICK_END) begin
                            tick_n  = '0;
                            mis_n   = rx_sync_s != expected_parity(16'(shift_r), parity_odd);
                            state_n = ST_STOP;
                        end else begin
                            tick_n = tick_r + TW'(1);
                        end
                    end else begin
                        tick_n = tick_r;
                    end
                end
`endif
                ST_STOP: begin
                    if (s_tick) begin
                        if (tick_r == TICK_END) begin
                            tick_n  = '0;
                            data_n  = shift_r;
                            state_n = ST_IDLE;
                            if (rx_sync_s) begin
                                valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                                perr_n  = mis_r;
`else
                                perr_n  = 1'b0;
`endif
                            end else begin
                                ferr_n = 1'b1;
                            end
                        end else begin
                            tick_n = tick_r + TW'(1);
                        end
                    end else begin
                        tick_n = tick_r;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    tick_n  = '0;
                    bit_n   = '0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_r;
    assign bus.rx_valid   = valid_r;
    assign bus.frame_err  = ferr_r;
    assign bus.parity_err = perr_r;
    assign bus.rx_busy    = busy_r;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: the bench drives serial frames and checks every output pulse against an expected-frame queue.
module tb_uart_rx;
    localparam int  OS   = 16;
    localparam int  TDIV = 4;
    localparam int  BIT  = OS * TDIV;
    localparam bit  PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam bit  PAR_EN = 1'b1;
`else
    localparam bit  PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic clk, rst_n, s_tick, rx_en, rx;
    int   total = 0;
    int   bad = 0;
    int   valid_cnt = 0;
    int   pulse_cnt = 0;
    exp_t exp_q[$];

    uart_rx_if #(.data_bits(8)) ifc ();

    uart_rx #(.oversample(OS), .data_bits(8), .parity_odd(PODD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_tick (s_tick),
        .rx_en  (rx_en),
        .rx     (rx),
        .bus    (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (TDIV - 1) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic bit_time(input logic lvl);
        rx = lvl;
        repeat (BIT) @(negedge clk);
    endtask

    // Leaves rx at the stop level; callers return the line to idle themselves
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input logic par_lvl);
        exp_t e;
        e.d  = d;
        e.fe = ~stop_lvl;
        e.pe = PAR_EN && stop_lvl && (par_lvl != ((^d) ^ PODD));
        exp_q.push_back(e);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        if (PAR_EN) bit_time(par_lvl);
        bit_time(stop_lvl);
    endtask

    initial begin
        int          v0, p0;
        logic [7:0]  tbl [4];
        logic [7:0]  d5;
        tbl[0] = 8'h00; tbl[1] = 8'h80; tbl[2] = 8'h01; tbl[3] = 8'hC3;

        // Compare process: every output pulse must match the next expected frame
        fork
            forever begin
                @(negedge clk);
                if (ifc.rx_valid || ifc.frame_err || ifc.parity_err) begin
                    exp_t e;
                    pulse_cnt++;
                    if (ifc.rx_valid) valid_cnt++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse got valid=%b ferr=%b perr=%b data=%h want no pulse",
                                 ifc.rx_valid, ifc.frame_err, ifc.parity_err, ifc.data_out);
                    end else begin
                        e = exp_q.pop_front();
                        if ({ifc.data_out, ifc.rx_valid, ifc.frame_err, ifc.parity_err} !== {e.d, ~e.fe, e.fe, e.pe}) begin
                            bad++;
                            $display("FAIL frame_result got data=%h valid=%b ferr=%b perr=%b want data=%h valid=%b ferr=%b perr=%b",
                                     ifc.data_out, ifc.rx_valid, ifc.frame_err, ifc.parity_err, e.d, ~e.fe, e.fe, e.pe);
                        end
                    end
                end
            end
            begin
                repeat (60000) @(negedge clk);
                total++;
                bad++;
                $display("FAIL watchdog got timeout want completion");
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join_none

        rst_n = 1'b1; rx = 1'b1; rx_en = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_state", {ifc.data_out, ifc.rx_valid, ifc.rx_busy, ifc.frame_err, ifc.parity_err}, 32'h0);
        rst_n = 1'b0;
        bit_time(1'b1);

        // Single frame 0x55
        v0 = valid_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        bit_time(1'b1);
        check("t1_one_valid", valid_cnt - v0, 32'd1);
        check("t1_data", ifc.data_out, 32'h55);
        check("t1_busy_low", ifc.rx_busy, 32'd0);

        // Back-to-back frames, then a small pattern table
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1);
        bit_time(1'b1);
        check("t2_two_valid", valid_cnt - v0, 32'd2);
        check("t2_data", ifc.data_out, 32'hFF);
        v0 = valid_cnt;
        for (int i = 0; i < 4; i++) send_frame(tbl[i], 1'b1, ^tbl[i]);
        bit_time(1'b1);
        check("tbl_valid_count", valid_cnt - v0, 32'd4);
        check("tbl_last_data", ifc.data_out, 32'hC3);

        // Short start glitch of four ticks
        p0 = pulse_cnt;
        rx = 1'b0;
        repeat (4 * TDIV) @(negedge clk);
        check("t3_busy_in_start", ifc.rx_busy, 32'd1);
        rx = 1'b1;
        bit_time(1'b1);
        check("t3_no_pulse", pulse_cnt - p0, 32'd0);
        check("t3_back_idle", ifc.rx_busy, 32'd0);

        // Stop bit low, then line held low for 20 bits
        p0 = pulse_cnt; v0 = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20) bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b1);
        check("t4_one_ferr_pulse", pulse_cnt - p0, 32'd1);
        check("t4_no_valid", valid_cnt - v0, 32'd0);
        check("t4_data", ifc.data_out, 32'h3C);
        check("t4_idle", ifc.rx_busy, 32'd0);

        // rx_en dropped during data bit 3
        p0 = pulse_cnt;
        d5 = 8'h5A;
        bit_time(1'b0);
        for (int i = 0; i < 3; i++) bit_time(d5[i]);
        rx = d5[3];
        repeat (BIT / 2) @(negedge clk);
        check("t5_busy_in_data", ifc.rx_busy, 32'd1);
        rx_en = 1'b0;
        @(negedge clk);
        check("t5_idle_next_clk", ifc.rx_busy, 32'd0);
        repeat (BIT / 2) @(negedge clk);
        for (int i = 4; i < 8; i++) bit_time(d5[i]);
        bit_time(1'b1);
        rx_en = 1'b1;
        bit_time(1'b1);
        check("t5_no_pulse", pulse_cnt - p0, 32'd0);
        check("t5_data_kept", ifc.data_out, 32'h3C);

        // Reset asserted mid-data
        d5 = 8'h81;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(d5[i]);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_reset_mid_frame", {ifc.data_out, ifc.rx_valid, ifc.rx_busy, ifc.frame_err, ifc.parity_err}, 32'h0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        bit_time(1'b1);
        check("t5_no_pulse_after_reset", pulse_cnt - p0, 32'd0);

        // Recovery frame after the reset
        send_frame(8'h96, 1'b1, 1'b0);
        bit_time(1'b1);
        check("recover_data", ifc.data_out, 32'h96);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        v0 = valid_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        bit_time(1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        bit_time(1'b1);
        check("t6_two_valid", valid_cnt - v0, 32'd2);
        check("t6_data", ifc.data_out, 32'h07);
`endif

        check("model_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
